// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmit FSM state codes and a
// frame-length helper used by the serializer (and later the receiver).
package uart_pkg;

  localparam logic [1:0] PAR_NONE0 = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE3 = 2'b11;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t IDLE   = 3'd0;
  localparam tx_state_t START  = 3'd1;
  localparam tx_state_t DATA   = 3'd2;
  localparam tx_state_t PARITY = 3'd3;
  localparam tx_state_t STOP   = 3'd4;
  localparam tx_state_t BREAK  = 3'd5;

  // Total line bits in one frame: start + data + optional parity + stop.
  function automatic int frame_len(input int data_width, input int stop_bits,
                                   input bit par_en);
    return 1 + data_width + (par_en ? 1 : 0) + stop_bits;
  endfunction

  function automatic logic parity_enabled(input logic [1:0] ptype);
    logic en;
    case (ptype)
      PAR_ODD, PAR_EVEN:    en = 1'b1;
      PAR_NONE0, PAR_NONE3: en = 1'b0;
      default:              en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity over a DATA_WIDTH word; i_odd selects odd parity
// (bit makes the total count of ones odd), otherwise even parity.
module uart_parity_gen #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_odd,
  output logic                  o_parity
);

  assign o_parity = (^i_data) ^ i_odd;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer with a one-entry holding buffer for back-to-back
// frames. Define UART_TX_BREAK_EN to add the break_req input and BREAK state.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  baud_clk,
  input  logic                  reset,
  input  logic                  send,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            parity_type,
`ifdef UART_TX_BREAK_EN
  input  logic                  break_req,
`endif
  output logic                  ready,
  output logic                  data_tx,
  output logic                  active_flag,
  output logic                  done_flag
);

  localparam int CW      = $clog2(DATA_WIDTH + 1);
  // Minimum break length is one parity-less frame.
  localparam int BRK_MIN = frame_len(DATA_WIDTH, STOP_BITS, 1'b0);
  localparam int BW      = $clog2(BRK_MIN + 1);

  tx_state_t             r_state;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_buf_data;
  logic [1:0]            r_buf_par;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_bit;
  logic                  r_par_en;
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_brk_cnt;
  logic                  r_brk_stop;
  logic                  r_tx;
  logic                  r_active;
  logic                  r_done;

  tx_state_t             w_state_nxt;
  logic                  w_load;
  logic                  w_brk;
  logic                  w_buf_vld;
  logic                  w_par;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic                  w_out_bit;
  logic [CW-1:0]         w_cnt_nxt;
  logic [BW-1:0]         w_brk_cnt_nxt;
  logic                  w_brk_stop_nxt;
  logic                  w_tx_nxt;
  logic                  w_active_nxt;
  logic                  w_done_nxt;

`ifdef UART_TX_BREAK_EN
  assign w_brk = break_req;
`else
  assign w_brk = 1'b0;
`endif

  assign w_buf_vld   = ~r_ready;
  assign ready       = r_ready;
  assign data_tx     = r_tx;
  assign active_flag = r_active;
  assign done_flag   = r_done;

  uart_parity_gen #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .i_data   (r_buf_data),
    .i_odd    (r_buf_par == PAR_ODD),
    .o_parity (w_par)
  );

  always_ff @(posedge baud_clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state plus the datapath values that the registered outputs depend on.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_brk) w_state_nxt = BREAK;
        else if (w_buf_vld) begin
          w_load      = 1'b1;
          w_state_nxt = START;
        end
      end
      START:  w_state_nxt = DATA;
      DATA:   if (r_cnt == CW'(DATA_WIDTH - 1)) w_state_nxt = r_par_en ? PARITY : STOP;
      PARITY: w_state_nxt = STOP;
      STOP: begin
        if (r_cnt == CW'(STOP_BITS - 1)) begin
          if (w_brk) w_state_nxt = BREAK;
          else if (w_buf_vld) begin
            w_load      = 1'b1;
            w_state_nxt = START;
          end else w_state_nxt = IDLE;
        end
      end
      BREAK:  if (r_brk_cnt == BW'(BRK_MIN) && !w_brk) w_state_nxt = STOP;
      default: w_state_nxt = IDLE;
    endcase

    w_shift_nxt = r_shift;
    if (w_load) w_shift_nxt = r_buf_data;
    else if (r_state == DATA && w_state_nxt == DATA) begin
      if (MSB_FIRST != 0) w_shift_nxt = {r_shift[DATA_WIDTH-2:0], 1'b0};
      else                w_shift_nxt = {1'b0, r_shift[DATA_WIDTH-1:1]};
    end
    w_out_bit = (MSB_FIRST != 0) ? w_shift_nxt[DATA_WIDTH-1] : w_shift_nxt[0];

    w_cnt_nxt = '0;
    if (w_state_nxt == r_state && (r_state == DATA || r_state == STOP))
      w_cnt_nxt = r_cnt + CW'(1);

    w_brk_cnt_nxt = '0;
    if (w_state_nxt == BREAK) begin
      if (r_state != BREAK)                 w_brk_cnt_nxt = BW'(1);
      else if (r_brk_cnt == BW'(BRK_MIN))   w_brk_cnt_nxt = r_brk_cnt;
      else                                  w_brk_cnt_nxt = r_brk_cnt + BW'(1);
    end

    // Stop bits that close a break are not a frame end, so no done pulse.
    w_brk_stop_nxt = 1'b0;
    if (r_state == BREAK) w_brk_stop_nxt = 1'b1;
    else if (r_state == STOP && w_state_nxt == STOP) w_brk_stop_nxt = r_brk_stop;
  end

  // Outputs are computed for the upcoming state and registered.
  always_comb begin
    w_tx_nxt     = 1'b1;
    w_active_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    case (w_state_nxt)
      START: begin
        w_tx_nxt     = 1'b0;
        w_active_nxt = 1'b1;
      end
      DATA: begin
        w_tx_nxt     = w_out_bit;
        w_active_nxt = 1'b1;
      end
      PARITY: begin
        w_tx_nxt     = r_par_bit;
        w_active_nxt = 1'b1;
      end
      STOP: begin
        w_active_nxt = 1'b1;
        w_done_nxt   = (w_cnt_nxt == CW'(STOP_BITS - 1)) && !w_brk_stop_nxt;
      end
      BREAK: begin
        w_tx_nxt     = 1'b0;
        w_active_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      r_ready    <= 1'b1;
      r_buf_data <= '0;
      r_buf_par  <= PAR_NONE0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_par_en   <= 1'b0;
      r_cnt      <= '0;
      r_brk_cnt  <= '0;
      r_brk_stop <= 1'b0;
      r_tx       <= 1'b1;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_brk_cnt  <= w_brk_cnt_nxt;
      r_brk_stop <= w_brk_stop_nxt;
      r_tx       <= w_tx_nxt;
      r_active   <= w_active_nxt;
      r_done     <= w_done_nxt;
      if (w_load) begin
        r_par_bit <= w_par;
        r_par_en  <= parity_enabled(r_buf_par);
        r_ready   <= 1'b1;
      end
      // Capture and load are exclusive: capture needs an empty buffer.
      if (send && r_ready) begin
        r_buf_data <= data_in;
        r_buf_par  <= parity_type;
        r_ready    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: a queue-of-line-bits model checked every cycle
// on two configurations, plus literal frame patterns captured off the line.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       snd_a, brk_a, rdy_a, tx_a, act_a, dn_a;
  logic [7:0] din_a;
  logic [1:0] par_a;
  logic       snd_b, brk_b, rdy_b, tx_b, act_b, dn_b;
  logic [6:0] din_b;
  logic [1:0] par_b;

  uart_tx_serializer #(.DATA_WIDTH(8), .STOP_BITS(1), .MSB_FIRST(0)) u_a (
    .baud_clk(clk), .reset(rst), .send(snd_a), .data_in(din_a), .parity_type(par_a),
`ifdef UART_TX_BREAK_EN
    .break_req(brk_a),
`endif
    .ready(rdy_a), .data_tx(tx_a), .active_flag(act_a), .done_flag(dn_a));

  uart_tx_serializer #(.DATA_WIDTH(7), .STOP_BITS(2), .MSB_FIRST(1)) u_b (
    .baud_clk(clk), .reset(rst), .send(snd_b), .data_in(din_b), .parity_type(par_b),
`ifdef UART_TX_BREAK_EN
    .break_req(brk_b),
`endif
    .ready(rdy_b), .data_tx(tx_b), .active_flag(act_b), .done_flag(dn_b));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each instance holds a queue of pending line bits {tx, done}.
  localparam int QN = 64;
  logic [1:0] mq [2][QN];
  int         mh [2];
  int         mc [2];
  bit         bv [2];
  logic [8:0] bd [2];
  logic [1:0] bp [2];
  bit         bm [2];
  int         bc [2];
  int         dwm [2] = '{8, 7};
  int         sbm [2] = '{1, 2};
  bit         msm [2] = '{1'b0, 1'b1};

  task automatic push(input int k, input logic t, input logic d);
    mq[k][(mh[k] + mc[k]) % QN] = {t, d};
    mc[k]++;
  endtask

  task automatic push_frame(input int k);
    logic p;
    logic b;
    p = 1'b0;
    push(k, 1'b0, 1'b0);
    for (int i = 0; i < dwm[k]; i++) begin
      b = msm[k] ? bd[k][dwm[k]-1-i] : bd[k][i];
      p = p ^ b;
      push(k, b, 1'b0);
    end
    if (bp[k] == 2'b01) push(k, ~p, 1'b0);
    if (bp[k] == 2'b10) push(k, p, 1'b0);
    for (int j = 0; j < sbm[k]; j++) push(k, 1'b1, j == sbm[k] - 1);
  endtask

  task automatic step(input int k, input logic r, input logic s, input logic [8:0] d,
                      input logic [1:0] pt, input logic br);
    bit rdy0;
    if (r) begin
      mc[k] = 0; mh[k] = 0; bv[k] = 0; bm[k] = 0; bc[k] = 0;
      return;
    end
    rdy0 = !bv[k];
    if (bm[k]) begin
      if (bc[k] >= 1 + dwm[k] + sbm[k] && !br) begin
        bm[k] = 0;
        for (int j = 0; j < sbm[k]; j++) push(k, 1'b1, 1'b0);
      end else bc[k]++;
    end else begin
      if (mc[k] > 0) begin
        mh[k] = (mh[k] + 1) % QN;
        mc[k]--;
      end
      if (mc[k] == 0) begin
        if (br) begin
          bm[k] = 1; bc[k] = 1;
        end else if (bv[k]) begin
          push_frame(k);
          bv[k] = 0;
        end
      end
    end
    if (s && rdy0) begin
      bv[k] = 1; bd[k] = d; bp[k] = pt;
    end
  endtask

  function automatic logic etx(input int k);
    if (bm[k]) return 1'b0;
    if (mc[k] > 0) return mq[k][mh[k]][1];
    return 1'b1;
  endfunction
  function automatic logic eact(input int k);
    return bm[k] || (mc[k] > 0);
  endfunction
  function automatic logic edone(input int k);
    return !bm[k] && (mc[k] > 0) && mq[k][mh[k]][0];
  endfunction

  always @(posedge clk) begin
    step(0, rst, snd_a, {1'b0, din_a}, par_a, brk_a);
    step(1, rst, snd_b, {2'b00, din_b}, par_b, brk_b);
  end

  always @(negedge clk) begin
    chk("tx_a", tx_a, etx(0));
    chk("active_a", act_a, eact(0));
    chk("done_a", dn_a, edone(0));
    chk("ready_a", rdy_a, !bv[0]);
    chk("tx_b", tx_b, etx(1));
    chk("active_b", act_b, eact(1));
    chk("done_b", dn_b, edone(1));
    chk("ready_b", rdy_b, !bv[1]);
  end

  task automatic send_a(input logic [7:0] d, input logic [1:0] p);
    @(negedge clk); snd_a = 1'b1; din_a = d; par_a = p;
    @(negedge clk); snd_a = 1'b0;
  endtask
  task automatic send_b(input logic [6:0] d, input logic [1:0] p);
    @(negedge clk); snd_b = 1'b1; din_b = d; par_b = p;
    @(negedge clk); snd_b = 1'b0;
  endtask

  // Wait (bounded) for the line to go active, then record n bits, first bit in the MSB.
  task automatic cap_a(input int n, output logic [31:0] v);
    int t = 0;
    v = '0;
    while (!act_a && t < 60) begin @(negedge clk); t++; end
    chk("cap_a_active", act_a, 1);
    for (int i = 0; i < n; i++) begin
      v = {v[30:0], tx_a};
      if (i < n - 1) @(negedge clk);
    end
  endtask
  task automatic cap_b(input int n, output logic [31:0] v);
    int t = 0;
    v = '0;
    while (!act_b && t < 60) begin @(negedge clk); t++; end
    chk("cap_b_active", act_b, 1);
    for (int i = 0; i < n; i++) begin
      v = {v[30:0], tx_b};
      if (i < n - 1) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1; snd_a = 0; din_a = 0; par_a = 0; brk_a = 0;
    snd_b = 0; din_b = 0; par_b = 0; brk_b = 0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_a, 1);
    chk("rst_active", act_a, 0);
    chk("rst_done", dn_a, 0);
    chk("rst_ready", rdy_a, 1);
    rst = 1'b0;

    send_a(8'hA5, 2'b00);
    cap_a(10, v);
    chk("frame_a5", v, 32'b0101001011);
    repeat (3) @(negedge clk);

    send_a(8'h03, 2'b01);
    cap_a(11, v);
    chk("frame_03_odd", v, 32'b01100000011);
    repeat (2) @(negedge clk);

    // parity_type changes mid-frame must not affect the frame in flight
    send_a(8'h03, 2'b10);
    fork
      cap_a(11, v);
      begin repeat (3) @(negedge clk); par_a = 2'b01; end
    join
    chk("frame_03_even", v, 32'b01100000001);
    repeat (3) @(negedge clk);

    send_a(8'h55, 2'b00);
    fork
      cap_a(20, v);
      begin
        send_a(8'hF0, 2'b00);
        chk("full_ready", rdy_a, 0);
        send_a(8'h00, 2'b00);
      end
    join
    chk("frame_b2b", v, 32'b01010101010000011111);
    repeat (4) @(negedge clk);
    chk("b2b_idle_ready", rdy_a, 1);
    chk("b2b_idle_active", act_a, 0);

    send_a(8'h11, 2'b00);
    send_a(8'h22, 2'b00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tx", tx_a, 1);
    chk("abort_active", act_a, 0);
    chk("abort_ready", rdy_a, 1);
    send_a(8'hC3, 2'b00);
    cap_a(10, v);
    chk("frame_c3", v, 32'b0110000111);
    repeat (4) @(negedge clk);

    send_b(7'h41, 2'b00);
    cap_b(10, v);
    chk("frame_b41", v, 32'b0100000111);
    repeat (3) @(negedge clk);
    send_b(7'h41, 2'b10);
    cap_b(11, v);
    chk("frame_b41_even", v, 32'b01000001011);
    repeat (4) @(negedge clk);

`ifdef UART_TX_BREAK_EN
    fork
      cap_a(17, v);
      begin @(negedge clk); brk_a = 1'b1; repeat (15) @(negedge clk); brk_a = 1'b0; end
    join
    chk("break_15", v, 32'b00000000000000011);
    repeat (4) @(negedge clk);
    fork
      cap_a(12, v);
      begin @(negedge clk); brk_a = 1'b1; repeat (3) @(negedge clk); brk_a = 1'b0; end
    join
    chk("break_min", v, 32'b000000000011);
    repeat (4) @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
